// File: rtl/regfile_pkg.sv
// Shared constants and types for the dual-writeback register file with pending scoreboard.
package regfile_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int REG_ZERO = 0;

    // One writeback port: enable, target register, data.
    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] wn;
        logic [DW_DEF-1:0] d;
    } wb_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of regfile_sb: two read ports, two writeback ports, issue port.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) ();

    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic          busy_a;
    logic          busy_b;

    logic          we0;
    logic [AW-1:0] wn0;
    logic [DW-1:0] d0;
    logic          we1;
    logic [AW-1:0] wn1;
    logic [DW-1:0] d1;

    // Issue handshake: iss_v is a valid with no ready. The register file always
    // accepts, and the issue takes effect at the rising edge where iss_v is high.
    logic          iss_v;
    logic [AW-1:0] iss_rn;

    logic [AW:0]   pend_cnt;

    modport master (
        output rna, rnb, we0, wn0, d0, we1, wn1, d1, iss_v, iss_rn,
        input  qa, qb, busy_a, busy_b, pend_cnt
    );

    modport slave (
        input  rna, rnb, we0, wn0, d0, we1, wn1, d1, iss_v, iss_rn,
        output qa, qb, busy_a, busy_b, pend_cnt
    );

endinterface

// File: rtl/rf_bypass_mux.sv
// Per-read-port same-cycle forwarding selector; built only with REGFILE_BYPASS_EN defined.
`ifdef REGFILE_BYPASS_EN
module rf_bypass_mux #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] rn,
    input  logic [DW-1:0] arr_q,
    input  logic          arr_busy,
    input  logic          wr0,
    input  logic [AW-1:0] wn0,
    input  logic [DW-1:0] d0,
    input  logic          wr1,
    input  logic [AW-1:0] wn1,
    input  logic [DW-1:0] d1,
    input  logic          iss,
    input  logic [AW-1:0] iss_rn,
    output logic [DW-1:0] q,
    output logic          busy
);

    logic hit0;
    logic hit1;

    assign hit0 = wr0 && (wn0 == rn);
    assign hit1 = wr1 && (wn1 == rn);

    always_comb begin
        q    = arr_q;
        busy = arr_busy;
        if (hit1) begin
            q = d1;
        end else if (hit0) begin
            q = d0;
        end
        // A landing writeback retires the producer unless a newer one issues now.
        if ((hit0 || hit1) && !(iss && (iss_rn == rn))) begin
            busy = 1'b0;
        end
    end

endmodule
`endif

// File: rtl/regfile_sb.sv
// Two-write/two-read register file with per-register pending scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic         clk,
    input  logic         clrn,
    regfile_sb_if.slave  bus
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [AW:0]      cnt;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_R0 && (a == AW'(REG_ZERO));
    endfunction

    logic wr0, wr1, wr0_keep, iss;
    logic inc, dec0, dec1;

    assign wr0 = bus.we0 && !is_zero(bus.wn0);
    assign wr1 = bus.we1 && !is_zero(bus.wn1);
    assign iss = bus.iss_v && !is_zero(bus.iss_rn);

    // Port 1 wins a same-address dual write, so port 0 is dropped entirely.
    assign wr0_keep = wr0 && !(wr1 && (bus.wn0 == bus.wn1));

    assign inc  = iss && !pend[bus.iss_rn];
    assign dec0 = wr0_keep && pend[bus.wn0] && !(iss && (bus.iss_rn == bus.wn0));
    assign dec1 = wr1 && pend[bus.wn1] && !(iss && (bus.iss_rn == bus.wn1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
            cnt  <= '0;
        end else begin
            if (wr0_keep) mem[bus.wn0] <= bus.d0;
            if (wr1)      mem[bus.wn1] <= bus.d1;
            if (wr0)      pend[bus.wn0] <= 1'b0;
            if (wr1)      pend[bus.wn1] <= 1'b0;
            // Issue is the newer producer, so its set overrides a same-edge clear.
            if (iss)      pend[bus.iss_rn] <= 1'b1;
            cnt <= cnt + (AW+1)'(inc) - (AW+1)'(dec0) - (AW+1)'(dec1);
        end
    end

    logic [DW-1:0] arr_a, arr_b;
    logic          st_busy_a, st_busy_b;

    assign arr_a     = is_zero(bus.rna) ? '0   : mem[bus.rna];
    assign arr_b     = is_zero(bus.rnb) ? '0   : mem[bus.rnb];
    assign st_busy_a = is_zero(bus.rna) ? 1'b0 : pend[bus.rna];
    assign st_busy_b = is_zero(bus.rnb) ? 1'b0 : pend[bus.rnb];

`ifdef REGFILE_BYPASS_EN
    rf_bypass_mux #(.DW(DW), .AW(AW)) u_byp_a (
        .rn(bus.rna), .arr_q(arr_a), .arr_busy(st_busy_a),
        .wr0(wr0), .wn0(bus.wn0), .d0(bus.d0),
        .wr1(wr1), .wn1(bus.wn1), .d1(bus.d1),
        .iss(iss), .iss_rn(bus.iss_rn),
        .q(bus.qa), .busy(bus.busy_a)
    );

    rf_bypass_mux #(.DW(DW), .AW(AW)) u_byp_b (
        .rn(bus.rnb), .arr_q(arr_b), .arr_busy(st_busy_b),
        .wr0(wr0), .wn0(bus.wn0), .d0(bus.d0),
        .wr1(wr1), .wn1(bus.wn1), .d1(bus.d1),
        .iss(iss), .iss_rn(bus.iss_rn),
        .q(bus.qb), .busy(bus.busy_b)
    );
`else
    assign bus.qa     = arr_a;
    assign bus.qb     = arr_b;
    assign bus.busy_a = st_busy_a;
    assign bus.busy_b = st_busy_b;
`endif

    assign bus.pend_cnt = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk;
    logic clrn;

    regfile_sb_if #(.DW(32), .AW(5)) bus ();

    regfile_sb #(.DW(32), .AW(5), .ZERO_R0(1'b1)) dut (
        .clk(clk),
        .clrn(clrn),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: register values and pending flags, register 0 held at zero.
    logic [31:0] m_mem [32];
    bit          m_pend [32];

    function automatic int model_cnt();
        int s = 0;
        for (int i = 0; i < 32; i++) s += int'(m_pend[i]);
        return s;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Edge behaviour from the rules: writes in port order, clears, then the issue sets.
    function automatic void model_edge();
        if (bus.we0 && bus.wn0 != 5'd0) m_mem[bus.wn0] = bus.d0;
        if (bus.we1 && bus.wn1 != 5'd0) m_mem[bus.wn1] = bus.d1;
        if (bus.we0 && bus.wn0 != 5'd0) m_pend[bus.wn0] = 1'b0;
        if (bus.we1 && bus.wn1 != 5'd0) m_pend[bus.wn1] = 1'b0;
        if (bus.iss_v && bus.iss_rn != 5'd0) m_pend[bus.iss_rn] = 1'b1;
    endfunction

    function automatic logic [31:0] exp_q(input logic [4:0] rn);
        if (rn == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (bus.we1 && bus.wn1 == rn) return bus.d1;
        if (bus.we0 && bus.wn0 == rn) return bus.d0;
`endif
        return m_mem[rn];
    endfunction

    function automatic logic exp_busy(input logic [4:0] rn);
        if (rn == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((bus.we0 && bus.wn0 == rn) || (bus.we1 && bus.wn1 == rn)) &&
            !(bus.iss_v && bus.iss_rn == rn)) return 1'b0;
`endif
        return m_pend[rn];
    endfunction

    task automatic drive_idle();
        bus.we0 = 1'b0; bus.wn0 = '0; bus.d0 = '0;
        bus.we1 = 1'b0; bus.wn1 = '0; bus.d1 = '0;
        bus.iss_v = 1'b0; bus.iss_rn = '0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step();
        @(posedge clk);
        if (clrn) model_edge();
        @(negedge clk);
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            bus.rna = 5'($urandom_range(0, 31));
            bus.rnb = 5'($urandom_range(0, 31));
            #1;
            n_checks++;
            if (bus.qa !== 32'h0 || bus.qb !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_q: qa=%h qb=%h expected 0", bus.qa, bus.qb);
            end
            n_checks++;
            if (bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0 || bus.pend_cnt !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_busy: busy_a=%b busy_b=%b pend_cnt=%0d expected 0/0/0",
                         bus.busy_a, bus.busy_b, bus.pend_cnt);
            end
        end
    endtask

    task automatic test_r0_guard();
        bus.we0 = 1'b1; bus.wn0 = 5'd0; bus.d0 = 32'hFFFF_FFFF;
        bus.iss_v = 1'b1; bus.iss_rn = 5'd0;
        step();
        drive_idle();
        bus.rna = 5'd0;
        #1;
        n_checks++;
        if (bus.qa !== 32'h0 || bus.busy_a !== 1'b0 || bus.pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL r0_guard: qa=%h busy_a=%b pend_cnt=%0d expected 0/0/0",
                     bus.qa, bus.busy_a, bus.pend_cnt);
        end
    endtask

    task automatic test_dual_write();
        bus.we0 = 1'b1; bus.wn0 = 5'd7; bus.d0 = 32'hAAAA_AAAA;
        bus.we1 = 1'b1; bus.wn1 = 5'd7; bus.d1 = 32'h5555_5555;
        step();
        drive_idle();
        bus.rna = 5'd7;
        #1;
        n_checks++;
        if (bus.qa !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL dual_write: qa=%h expected 55555555", bus.qa);
        end
    endtask

    task automatic test_scoreboard();
        logic [4:0] seq [3] = '{5'd3, 5'd4, 5'd3};
        foreach (seq[i]) begin
            bus.iss_v = 1'b1; bus.iss_rn = seq[i];
            step();
        end
        drive_idle();
        bus.rna = 5'd3; bus.rnb = 5'd4;
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd2 || bus.busy_a !== 1'b1 || bus.busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_issue: pend_cnt=%0d busy_a=%b busy_b=%b expected 2/1/1",
                     bus.pend_cnt, bus.busy_a, bus.busy_b);
        end
        bus.we0 = 1'b1; bus.wn0 = 5'd3; bus.d0 = 32'h33;
        bus.we1 = 1'b1; bus.wn1 = 5'd4; bus.d1 = 32'h44;
        step();
        drive_idle();
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd0 || bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_writeback: pend_cnt=%0d busy_a=%b busy_b=%b expected 0/0/0",
                     bus.pend_cnt, bus.busy_a, bus.busy_b);
        end
    endtask

    task automatic test_collision();
        bus.iss_v = 1'b1; bus.iss_rn = 5'd5;
        step();
        bus.we0 = 1'b1; bus.wn0 = 5'd5; bus.d0 = 32'd9;
        step();
        drive_idle();
        bus.rna = 5'd5;
        #1;
        n_checks++;
        if (bus.qa !== 32'd9 || bus.busy_a !== 1'b1 || bus.pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL collision: qa=%0d busy_a=%b pend_cnt=%0d expected 9/1/1",
                     bus.qa, bus.busy_a, bus.pend_cnt);
        end
        bus.we0 = 1'b1; bus.wn0 = 5'd5; bus.d0 = 32'd9;
        step();
        drive_idle();
        #1;
        n_checks++;
        if (bus.busy_a !== 1'b0 || bus.pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL collision_retire: busy_a=%b pend_cnt=%0d expected 0/0",
                     bus.busy_a, bus.pend_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        bus.we0 = 1'b1; bus.wn0 = 5'd12; bus.d0 = 32'hCAFE;
        step();
        drive_idle();
        bus.rna = 5'd12;
        bus.we1 = 1'b1; bus.wn1 = 5'd12; bus.d1 = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'h1234;
`else
        want = 32'hCAFE;
`endif
        n_checks++;
        if (bus.qa !== want || bus.busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: qa=%h busy_a=%b expected %h/0", bus.qa, bus.busy_a, want);
        end
        step();
        drive_idle();
        #1;
        n_checks++;
        if (bus.qa !== 32'h1234) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: qa=%h expected 00001234", bus.qa);
        end
    endtask

    task automatic test_random();
        wb_t w0, w1;
        for (int c = 0; c < 400; c++) begin
            w0.we = 1'($urandom_range(0, 1)); w0.wn = rand_addr(); w0.d = $urandom();
            w1.we = 1'($urandom_range(0, 1)); w1.wn = rand_addr(); w1.d = $urandom();
            bus.we0 = w0.we; bus.wn0 = w0.wn; bus.d0 = w0.d;
            bus.we1 = w1.we; bus.wn1 = w1.wn; bus.d1 = w1.d;
            bus.iss_v  = ($urandom_range(0, 2) != 0);
            bus.iss_rn = rand_addr();
            bus.rna = rand_addr();
            bus.rnb = rand_addr();
            #1;
            n_checks++;
            if (bus.qa !== exp_q(bus.rna)) begin
                n_fail++;
                $display("FAIL rand_qa c=%0d rna=%0d: qa=%h expected %h", c, bus.rna, bus.qa, exp_q(bus.rna));
            end
            n_checks++;
            if (bus.qb !== exp_q(bus.rnb)) begin
                n_fail++;
                $display("FAIL rand_qb c=%0d rnb=%0d: qb=%h expected %h", c, bus.rnb, bus.qb, exp_q(bus.rnb));
            end
            n_checks++;
            if (bus.busy_a !== exp_busy(bus.rna) || bus.busy_b !== exp_busy(bus.rnb)) begin
                n_fail++;
                $display("FAIL rand_busy c=%0d: busy_a=%b busy_b=%b expected %b/%b", c,
                         bus.busy_a, bus.busy_b, exp_busy(bus.rna), exp_busy(bus.rnb));
            end
            n_checks++;
            if (int'(bus.pend_cnt) !== model_cnt()) begin
                n_fail++;
                $display("FAIL rand_pend_cnt c=%0d: pend_cnt=%0d expected %0d", c, bus.pend_cnt, model_cnt());
            end
            step();
        end
        drive_idle();
    endtask

    task automatic test_reset_midcycle();
        for (int i = 0; i < 10; i++) begin
            bus.we0 = 1'b1; bus.wn0 = 5'(8 + i); bus.d0 = $urandom() | 32'h1;
            bus.iss_v = 1'b1; bus.iss_rn = 5'(20 + i);
            step();
        end
        drive_idle();
        bus.rna = 5'd8; bus.rnb = 5'd20;
        #2;
        clrn = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (bus.qa !== 32'h0 || bus.qb !== 32'h0 || bus.busy_b !== 1'b0 || bus.pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_async: qa=%h qb=%h busy_b=%b pend_cnt=%0d expected all 0",
                     bus.qa, bus.qb, bus.busy_b, bus.pend_cnt);
        end
        // Activity while reset is held must not land.
        bus.we1 = 1'b1; bus.wn1 = 5'd9; bus.d1 = 32'hDEAD_BEEF;
        bus.iss_v = 1'b1; bus.iss_rn = 5'd21;
        step();
        drive_idle();
        clrn = 1'b1;
        bus.rna = 5'd9; bus.rnb = 5'd21;
        #1;
        n_checks++;
        if (bus.qa !== 32'h0 || bus.busy_b !== 1'b0 || bus.pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_precedence: qa=%h busy_b=%b pend_cnt=%0d expected 0/0/0",
                     bus.qa, bus.busy_b, bus.pend_cnt);
        end
    endtask

    initial begin
        clrn = 1'b0;
        drive_idle();
        bus.rna = '0;
        bus.rnb = '0;
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        clrn = 1'b1;
        @(negedge clk);
        test_r0_guard();
        test_dual_write();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_random();
        test_reset_midcycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised two-write/two-read register file with a per-register pending scoreboard.
- Successor to the single-port 32x32 regfile, for the dual-issue datapath: two writeback ports, and an issue port that marks destination registers busy until writeback.
- Sits between decode (issue, read) and the writeback stage.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW.
- ZERO_R0, 1, 1 = register 0 hardwired to zero, never written, never pending; 0 = register 0 is ordinary.

Ports:
- clk  input  1  clock, all state updates on rising edge
- clrn  input  1  asynchronous active-low reset
- rna  input  AW  read address port A
- rnb  input  AW  read address port B
- qa  output  DW  read data port A
- qb  output  DW  read data port B
- busy_a  output  1  register rna is pending
- busy_b  output  1  register rnb is pending
- we0  input  1  write enable, writeback port 0
- wn0  input  AW  write address, port 0
- d0  input  DW  write data, port 0
- we1  input  1  write enable, writeback port 1
- wn1  input  AW  write address, port 1
- d1  input  DW  write data, port 1
- iss_v  input  1  issue valid: mark iss_rn pending
- iss_rn  input  AW  destination register being issued
- pend_cnt  output  AW+1  number of registers currently pending

Behaviour:
- Reset: while clrn=0, asynchronously clear all registers, all pending bits and pend_cnt. Outputs then read qa=qb=0, busy_a=busy_b=0, pend_cnt=0.
- Reads are combinational from the array; zero added latency.
- With ZERO_R0=1, rna=0 gives qa=0 and busy_a=0; the same applies to port B.
- Write commits at the rising edge when weN=1.
- With ZERO_R0=1, a write to register 0 is dropped silently.
- Same-address dual write (we0=we1=1, wn0=wn1): port 1 wins; port 0 data is discarded.
- Writeback clears the pending bit of the target register at the same edge.
- Issue: iss_v=1 sets pend[iss_rn] at the edge.
- Issue and writeback to the same register in the same cycle: the register is written and the pending bit ends SET, because the issue is the newer producer.
- Issue to an already-pending register: the bit stays set and pend_cnt is unchanged.
- Writeback to a non-pending register: the register is written and pend_cnt is unchanged.
- pend_cnt: registered, and always equal to the popcount of the pending bits after each edge. Per-cycle delta = (+1 if issue sets a new bit) - (number of distinct registers cleared whose bit was set and is not re-set by the issue). Range 0..2**AW, which can never overflow with AW+1 bits.
- Without the optional feature, a read in the same cycle as a write to the same address returns the old value and old busy; the new value is visible the next cycle.
- Reset asserted mid-operation takes precedence over every write and issue in flight.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If weN=1 and wnN equals the read address (non-zero when ZERO_R0=1), qX = dN, with port 1 taking priority over port 0.
  - busy_X is forced to 0 when a write hits the read address this cycle, unless iss_v=1 with iss_rn equal to the same address.
  - This adds a combinational path from d0/d1 to qa/qb.
- Undefined: reads come from state only, as above; no d-to-q path.

Decomposition:
- Shared package regfile_pkg holds:
  - default DW/AW constants;
  - typedef for a writeback bundle {we, wn, d};
  - REG_ZERO address constant.
- One natural sub-module: rf_bypass_mux.
  - Per-read-port selector choosing array data, d0 or d1, plus the busy override.
  - Instantiated twice; present only under REGFILE_BYPASS_EN.

Test Plan:
- Reset: clrn=0 asynchronously mid-cycle after 10 arbitrary writes -> all qa/qb=0, busy=0, pend_cnt=0 immediately, before the next clk edge.
- Dual write conflict: we0=we1=1, wn0=wn1=7, d0=32'hAAAA_AAAA, d1=32'h5555_5555 -> next cycle rna=7 gives qa=32'h5555_5555.
- R0 guard (ZERO_R0=1): write d0=32'hFFFF_FFFF to wn0=0, and iss_rn=0 -> qa=0, busy_a=0, pend_cnt=0.
- Scoreboard sequence:
  - issue r3, r4, r3 over 3 cycles -> pend_cnt=2 and busy on r3 and r4;
  - then writeback r3 and r4 together -> pend_cnt=0.
- Issue+writeback collision: pend[5]=1, same cycle iss_rn=5 and we0 wn0=5 d0=9 -> r5=9, busy stays 1, pend_cnt unchanged.
- Bypass: rna=wn1=12, we1=1, d1=32'h1234 in the same cycle:
  - macro defined -> qa=32'h1234, busy_a=0;
  - macro undefined -> qa=old value, new value visible next cycle.
